// File: rtl/seq_pkg.sv
// seq_pkg: shared types and default word width for the sequence-detector path.
package seq_pkg;
   localparam int SEQ_WORD_W = 8;
   typedef enum logic [0:0] {IDLE = 1'b0, SHIFT = 1'b1} ser_state_t;
endpackage

// File: rtl/seq_bit_serializer_if.sv
// seq_bit_serializer_if: word handshake in, qualified serial bit out.
interface seq_bit_serializer_if
   import seq_pkg::*;
   #(parameter int WIDTH = SEQ_WORD_W);
   logic [WIDTH-1:0] in_data;
   logic             in_valid;
   logic             in_ready;
   logic             en;
   logic             x;
   logic             x_valid;
   logic             x_last;
   modport master (output in_data, in_valid, en, input in_ready, x, x_valid, x_last);
   modport slave  (input in_data, in_valid, en, output in_ready, x, x_valid, x_last);
endinterface

// File: rtl/ser_hold_buf.sv
// ser_hold_buf: single-entry holding register that lets the next word wait
// while the current one is still shifting out.
module ser_hold_buf
   import seq_pkg::*;
   #(parameter int WIDTH = SEQ_WORD_W)
   (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] in_data,
   input  logic             in_valid,
   input  logic             wr_en,
   input  logic             drain,
   output logic             in_ready,
   output logic             hold_full,
   output logic [WIDTH-1:0] hold_data
   );
   logic             full_d, full_q, wr;
   logic [WIDTH-1:0] data_d, data_q;
   always_comb begin
      in_ready = !full_q;
      wr       = in_valid && in_ready && wr_en;
      data_d   = wr ? in_data : data_q;
      full_d   = wr ? 1'b1 : (drain ? 1'b0 : full_q);
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         full_q <= 1'b0;
         data_q <= '0;
      end else begin
         full_q <= full_d;
         data_q <= data_d;
      end
   end
   assign hold_full = full_q;
   assign hold_data = data_q;
endmodule

// File: rtl/seq_bit_serializer.sv
// seq_bit_serializer: parallel-to-serial front end for the sequence detector.
// Bit order is MSB first unless SER_LSB_FIRST_EN is defined.
module seq_bit_serializer
   import seq_pkg::*;
   #(parameter int WIDTH = SEQ_WORD_W)
   (
   input  logic                 clk,
   input  logic                 rst_n,
   seq_bit_serializer_if.slave  bus
   );
   localparam int CNT_W = $clog2(WIDTH);
   ser_state_t       state_d, state_q;
   logic [WIDTH-1:0] shreg_d, shreg_q, shifted, hold_data;
   logic [CNT_W-1:0] bit_cnt_d, bit_cnt_q;
   logic             in_ready, hold_full, take, drain, hold_wr, x_valid, x_last;
   ser_hold_buf #(.WIDTH(WIDTH)) u_hold (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_data   (bus.in_data),
      .in_valid  (bus.in_valid),
      .wr_en     (hold_wr),
      .drain     (drain),
      .in_ready  (in_ready),
      .hold_full (hold_full),
      .hold_data (hold_data)
   );
`ifdef SER_LSB_FIRST_EN
   assign shifted = {1'b0, shreg_q[WIDTH-1:1]};
   assign bus.x   = shreg_q[0];
`else
   assign shifted = {shreg_q[WIDTH-2:0], 1'b0};
   assign bus.x   = shreg_q[WIDTH-1];
`endif
   always_comb begin
      x_valid   = (state_q == SHIFT) && bus.en;
      x_last    = x_valid && (bit_cnt_q == CNT_W'(WIDTH-1));
      take      = bus.in_valid && in_ready;
      drain     = x_last && hold_full;
      // on the last bit a fresh word bypasses hold straight into shreg
      hold_wr   = (state_q == SHIFT) && !x_last;
      state_d   = state_q;
      shreg_d   = shreg_q;
      bit_cnt_d = bit_cnt_q;
      if (state_q == IDLE) begin
         if (take) begin
            shreg_d   = bus.in_data;
            bit_cnt_d = '0;
            state_d   = SHIFT;
         end
      end else if (x_last) begin
         bit_cnt_d = '0;
         shreg_d   = hold_full ? hold_data : (take ? bus.in_data : shifted);
         state_d   = (hold_full || take) ? SHIFT : IDLE;
      end else if (bus.en) begin
         shreg_d   = shifted;
         bit_cnt_d = bit_cnt_q + CNT_W'(1);
      end
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         shreg_q   <= '0;
         bit_cnt_q <= '0;
      end else begin
         state_q   <= state_d;
         shreg_q   <= shreg_d;
         bit_cnt_q <= bit_cnt_d;
      end
   end
   assign bus.in_ready = in_ready;
   assign bus.x_valid  = x_valid;
   assign bus.x_last   = x_last;
endmodule

// File: tb/tb_seq_bit_serializer.sv
// tb_seq_bit_serializer: directed checks of handshake, bit order, en gating,
// hold drain and reset for seq_bit_serializer.
module tb_seq_bit_serializer;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int checks = 0;
   int failures = 0;
   seq_bit_serializer_if #(.WIDTH(8)) bus ();
   seq_bit_serializer #(.WIDTH(8)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
   always #5 clk = ~clk;
   initial begin
      #200000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end
   task automatic cyc();
      @(posedge clk);
      #1;
   endtask
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask
   function automatic logic bit_at(input logic [7:0] w, input int j);
`ifdef SER_LSB_FIRST_EN
      return w[j];
`else
      return w[7-j];
`endif
   endfunction
   initial begin
      logic [7:0]  w;
      logic [3:0]  hist;
      logic [15:0] zmask;
      int          j, stray;
      bus.in_data = '0;
      bus.in_valid = 1'b0;
      bus.en = 1'b1;
      cyc(); cyc();
      chk("reset_x", 32'(bus.x), 32'd0);
      chk("reset_x_valid", 32'(bus.x_valid), 32'd0);
      chk("reset_x_last", 32'(bus.x_last), 32'd0);
      chk("reset_in_ready", 32'(bus.in_ready), 32'd1);
      @(negedge clk);
      rst_n = 1'b1;
      // single word A5
      cyc();
      bus.in_valid = 1'b1;
      bus.in_data = 8'hA5;
      cyc();
      bus.in_valid = 1'b0;
      w = 8'hA5;
      for (int i = 0; i < 8; i++) begin
         #1;
         chk("a5_x_valid", 32'(bus.x_valid), 32'd1);
         chk("a5_x", 32'(bus.x), 32'(bit_at(w, i)));
         chk("a5_x_last", 32'(bus.x_last), 32'(i == 7));
         cyc();
      end
      #1;
      chk("a5_idle_x_valid", 32'(bus.x_valid), 32'd0);
      chk("a5_idle_in_ready", 32'(bus.in_ready), 32'd1);
      // back-to-back AA then 0F through the 1010 detector model
      cyc();
      bus.in_valid = 1'b1;
      bus.in_data = 8'hAA;
      cyc();
      bus.in_data = 8'h0F;
      hist = '0;
      zmask = '0;
      for (int i = 0; i < 16; i++) begin
         if (i == 1) bus.in_valid = 1'b0;
         #1;
         w = (i < 8) ? 8'hAA : 8'h0F;
         chk("b2b_x_valid", 32'(bus.x_valid), 32'd1);
         chk("b2b_x", 32'(bus.x), 32'(bit_at(w, i % 8)));
         chk("b2b_x_last", 32'(bus.x_last), 32'(i % 8 == 7));
         chk("b2b_in_ready", 32'(bus.in_ready), 32'(i == 0 || i >= 8));
         hist = {hist[2:0], bus.x};
         if (hist == 4'b1010) zmask[i] = 1'b1;
         cyc();
      end
      #1;
      chk("b2b_end_x_valid", 32'(bus.x_valid), 32'd0);
`ifdef SER_LSB_FIRST_EN
      chk("b2b_z_bits", 32'(zmask), 32'h0050);
`else
      chk("b2b_z_bits", 32'(zmask), 32'h00A8);
`endif
      // C3 with en pattern 1,0,0,1,...
      cyc();
      bus.in_valid = 1'b1;
      bus.in_data = 8'hC3;
      cyc();
      bus.in_valid = 1'b0;
      w = 8'hC3;
      j = 0;
      for (int k = 0; k < 40 && j < 8; k++) begin
         bus.en = (k % 4 == 0) || (k % 4 == 3);
         #1;
         chk("en_x", 32'(bus.x), 32'(bit_at(w, j)));
         chk("en_x_valid", 32'(bus.x_valid), 32'(bus.en));
         chk("en_x_last", 32'(bus.x_last), 32'(bus.en && j == 7));
         if (bus.en) j++;
         cyc();
      end
      bus.en = 1'b1;
      #1;
      chk("en_bits_delivered", 32'(j), 32'd8);
      chk("en_end_x_valid", 32'(bus.x_valid), 32'd0);
      // last bit while hold is full and source still valid
      cyc();
      bus.in_valid = 1'b1;
      bus.in_data = 8'h81;
      cyc();
      for (int i = 0; i < 24; i++) begin
         bus.in_valid = (i < 16);
         bus.in_data = (i == 0) ? 8'h3C : 8'hE7;
         #1;
         w = (i < 8) ? 8'h81 : (i < 16) ? 8'h3C : 8'hE7;
         chk("hold_x_valid", 32'(bus.x_valid), 32'd1);
         chk("hold_x", 32'(bus.x), 32'(bit_at(w, i % 8)));
         chk("hold_x_last", 32'(bus.x_last), 32'(i % 8 == 7));
         chk("hold_in_ready", 32'(bus.in_ready), 32'(i == 0 || i == 8 || i >= 16));
         cyc();
      end
      bus.in_valid = 1'b0;
      #1;
      chk("hold_end_x_valid", 32'(bus.x_valid), 32'd0);
      // asynchronous reset mid-word with hold full
      cyc();
      bus.in_valid = 1'b1;
      bus.in_data = 8'hFF;
      cyc();
      cyc();
      bus.in_valid = 1'b0;
      cyc();
      #1;
      chk("pre_rst_in_ready", 32'(bus.in_ready), 32'd0);
      chk("pre_rst_x_valid", 32'(bus.x_valid), 32'd1);
      rst_n = 1'b0;
      #1;
      chk("rst_x_valid", 32'(bus.x_valid), 32'd0);
      chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
      chk("rst_x", 32'(bus.x), 32'd0);
      cyc();
      rst_n = 1'b1;
      stray = 0;
      for (int i = 0; i < 12; i++) begin
         #1;
         if (bus.x_valid || bus.x) stray++;
         cyc();
      end
      chk("post_rst_stray_bits", 32'(stray), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
